// File: rtl/fpu_addsub_ctrl_if.sv
// Bundle of request, adder and result signals for the FP add/sub issue/collect stage.
// master = requester/adder/writeback side, slave = the control block.
interface fpu_addsub_ctrl_if #(
  parameter int unsigned TAGW = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_sub;
  logic [31:0]     req_x1;
  logic [31:0]     req_x2;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     fu_x1;
  logic [31:0]     fu_x2;
  logic [31:0]     fu_y;
  logic            fu_ovf;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_y;
  logic            res_ovf;
  logic [TAGW-1:0] res_tag;
  logic            busy;

  modport master (
    output req_valid, req_sub, req_x1, req_x2, req_tag, fu_y, fu_ovf, res_ready,
    input  req_ready, fu_x1, fu_x2, res_valid, res_y, res_ovf, res_tag, busy
  );

  modport slave (
    input  req_valid, req_sub, req_x1, req_x2, req_tag, fu_y, fu_ovf, res_ready,
    output req_ready, fu_x1, fu_x2, res_valid, res_y, res_ovf, res_tag, busy
  );
endinterface

// File: rtl/fpu_addsub_ctrl.sv
// Issue/collect stage for a pipelined FP add/sub unit: credit-gated issue, LAT-deep
// valid/tag tracking pipe and a DEPTH-entry in-order result FIFO.
module fpu_addsub_ctrl #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  fpu_addsub_ctrl_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            ovf;
    logic [TAGW-1:0] tag;
    logic [31:0]     y;
  } res_entry_t;

  logic [LAT:0]    pipe_v;
  logic [TAGW-1:0] pipe_tag [LAT+1];
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  res_entry_t      mem [DEPTH];
  res_entry_t      head;
  logic            ready_q;
  logic            valid_q;
  logic            busy_q;
  logic [31:0]     fu_x1_q;
  logic [31:0]     fu_x2_q;
  logic            accept_c;
  logic            push_c;
  logic            pop_c;

  // Handshake events and next occupancy; credits come only from registered counts.
  always_comb begin
    accept_c     = bus.req_valid & ready_q;
    push_c       = pipe_v[LAT];
    pop_c        = bus.res_ready & valid_q;
    inflight_nxt = inflight + CW'(accept_c) - CW'(push_c);
    cnt_nxt      = fifo_cnt + CW'(push_c) - CW'(pop_c);
  end

  // Operand registers and the non-stalling valid/tag pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_x1_q <= '0;
      fu_x2_q <= '0;
      pipe_v  <= '0;
      for (int unsigned k = 0; k <= LAT; k++) pipe_tag[k] <= '0;
    end else begin
      if (accept_c) begin
        fu_x1_q <= bus.req_x1;
        fu_x2_q <= {bus.req_x2[31] ^ bus.req_sub, bus.req_x2[30:0]};
      end
      pipe_v[0]   <= accept_c;
      pipe_tag[0] <= bus.req_tag;
      for (int unsigned k = 1; k <= LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  // FIFO pointers, occupancy counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= cnt_nxt;
      inflight <= inflight_nxt;
      ready_q  <= (inflight_nxt + cnt_nxt) < CW'(DEPTH);
      valid_q  <= cnt_nxt != '0;
      busy_q   <= (inflight_nxt != '0) | (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{ovf: bus.fu_ovf, tag: pipe_tag[LAT], y: bus.fu_y};
  end

  // Every issued op owns a slot, so a push into a full FIFO without a pop is a credit leak.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_c && !pop_c && fifo_cnt == CW'(DEPTH)));

  assign head          = mem[rd_ptr];
  assign bus.req_ready = ready_q;
  assign bus.fu_x1     = fu_x1_q;
  assign bus.fu_x2     = fu_x2_q;
  assign bus.res_valid = valid_q;
  assign bus.res_y     = head.y;
  assign bus.res_ovf   = head.ovf;
  assign bus.res_tag   = head.tag;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Bench for fpu_addsub_ctrl: adder stub, scoreboard model of credits/latency/order,
// directed literal cases and a randomized phase.
module tb_fpu_addsub_ctrl;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 5;

  logic clk;
  logic rst;
  fpu_addsub_ctrl_if #(.TAGW(TAGW)) bus();

  fpu_addsub_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-precision <-> real helpers; subnormals flush to zero, rounding truncates.
  function automatic real s2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:23] == 8'd0) return 0.0;
    d = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [32:0] r2s(input real r);
    logic [63:0] d;
    int ue;
    d  = $realtobits(r);
    ue = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0 || ue <= 0) return {1'b0, d[63], 31'd0};
    if (ue >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    return {1'b0, d[63], 8'(ue), d[51:29]};
  endfunction

  // Returns {ovf, y} for x1 + x2 or x1 - x2.
  function automatic logic [32:0] fop(input logic sub, input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b0, 32'h7FC00000};
    return sub ? r2s(s2r(a) - s2r(b)) : r2s(s2r(a) + s2r(b));
  endfunction

  // External adder stub: one register stage on the presented operands.
  logic [31:0] add_y;
  logic        add_ovf;
  always @(posedge clk) {add_ovf, add_y} <= fop(1'b0, bus.fu_x1, bus.fu_x2);
  assign bus.fu_y   = add_y;
  assign bus.fu_ovf = add_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: accepted ops in order with the cycle their result must be visible.
  typedef struct {
    logic [31:0]     y;
    logic            ovf;
    logic [TAGW-1:0] tag;
    int              rdy;
  } exp_t;

  exp_t        q[$];
  exp_t        ent;
  int          cyc = 0;
  int          outstanding = 0;
  logic [31:0] exp_x1 = '0;
  logic [31:0] exp_x2 = '0;
  logic        exp_valid;
  logic        m_acc;
  logic        m_pop;
  logic [32:0] r;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      outstanding = 0;
      exp_x1 = '0;
      exp_x2 = '0;
    end else begin
      exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("req_ready", bus.req_ready, outstanding < DEPTH);
      chk("busy", bus.busy, outstanding != 0);
      chk("res_valid", bus.res_valid, exp_valid);
      chk("fu_x1", bus.fu_x1, exp_x1);
      chk("fu_x2", bus.fu_x2, exp_x2);
      if (exp_valid) begin
        chk("res_y", bus.res_y, q[0].y);
        chk("res_ovf", bus.res_ovf, q[0].ovf);
        chk("res_tag", bus.res_tag, q[0].tag);
      end
      m_acc = bus.req_valid && (outstanding < DEPTH);
      m_pop = bus.res_ready && exp_valid;
      if (m_pop) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (m_acc) begin
        r       = fop(bus.req_sub, bus.req_x1, bus.req_x2);
        ent.y   = r[31:0];
        ent.ovf = r[32];
        ent.tag = bus.req_tag;
        ent.rdy = cyc + LAT + 2;
        q.push_back(ent);
        outstanding++;
        exp_x1 = bus.req_x1;
        exp_x2 = bus.req_sub ? -$bitstoshortreal(bus.req_x2) == 0 ? {~bus.req_x2[31], bus.req_x2[30:0]} : {~bus.req_x2[31], bus.req_x2[30:0]} : bus.req_x2;
      end
    end
    cyc++;
  end

  // One cycle: decide acceptance from the pre-edge ready, return just after the edge.
  task automatic step(output logic acc);
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic sub, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [TAGW-1:0] tag);
    bus.req_sub = sub;
    bus.req_x1  = x1;
    bus.req_x2  = x2;
    bus.req_tag = tag;
  endtask

  task automatic send(input logic sub, input logic [31:0] x1, input logic [31:0] x2,
                      input logic [TAGW-1:0] tag);
    logic acc;
    acc = 1'b0;
    set_req(sub, x1, x2, tag);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    chk("send_accept", acc, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("drain_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  logic acc;
  int   n_acc;
  int   seen;
  logic [TAGW-1:0] tg;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    set_req(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_fu_x1", bus.fu_x1, 32'h0);
    chk("rst_fu_x2", bus.fu_x2, 32'h0);
    chk("rst_req_ready", bus.req_ready, 1'b1);

    // 1.0 + 2.0, tag 3: visible two edges after the accept edge.
    send(1'b0, 32'h3F800000, 32'h40000000, 5'd3);
    chk("add_fu_x1", bus.fu_x1, 32'h3F800000);
    chk("add_fu_x2", bus.fu_x2, 32'h40000000);
    @(posedge clk); #1;
    chk("add_early_valid", bus.res_valid, 1'b0);
    @(posedge clk); #1;
    chk("add_res_valid", bus.res_valid, 1'b1);
    chk("add_res_y", bus.res_y, 32'h40400000);
    chk("add_res_tag", bus.res_tag, 5'd3);
    chk("add_res_ovf", bus.res_ovf, 1'b0);
    drain();

    // 3.0 - 1.0 via sign flip on operand 2.
    send(1'b1, 32'h40400000, 32'h3F800000, 5'd4);
    chk("sub_fu_x2", bus.fu_x2, 32'hBF800000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sub_res_y", bus.res_y, 32'h40000000);
    chk("sub_res_tag", bus.res_tag, 5'd4);
    drain();

    send(1'b1, 32'h00000000, 32'h7FC00001, 5'd5);
    chk("nan_fu_x2", bus.fu_x2, 32'hFFC00001);
    drain();

    send(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ovf_res_y", bus.res_y, 32'h7F800000);
    chk("ovf_res_ovf", bus.res_ovf, 1'b1);
    drain();

    // Backpressure: only DEPTH credits exist.
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b1;
    n_acc = 0;
    tg = '0;
    for (int i = 0; i < 10; i++) begin
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(), tg);
      step(acc);
      if (acc) begin
        n_acc++;
        tg++;
        set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(), tg);
      end
    end
    chk("bp_accepts", 64'(n_acc), 64'(DEPTH));
    chk("bp_req_ready", bus.req_ready, 1'b0);

    // Release from full with continuous requests: one accept per cycle once primed.
    bus.res_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(), tg);
      step(acc);
      if (acc) begin
        tg++;
        if (i >= 8) n_acc++;
      end
    end
    chk("sustained_accepts", 64'(n_acc), 64'd12);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      bus.req_valid = $urandom_range(0, 3) != 0;
      bus.res_ready = $urandom_range(0, 2) != 0;
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(), TAGW'($urandom));
      step(acc);
    end
    drain();

    // Async reset with two queued and two in flight.
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b1;
    set_req(1'b0, 32'h3F800000, 32'h3F800000, 5'd20);
    step(acc);
    set_req(1'b0, 32'h40000000, 32'h3F800000, 5'd21);
    step(acc);
    bus.req_valid = 1'b0;
    repeat (3) step(acc);
    bus.req_valid = 1'b1;
    set_req(1'b1, 32'h40400000, 32'h3F800000, 5'd22);
    step(acc);
    set_req(1'b1, 32'h40800000, 32'h3F800000, 5'd23);
    step(acc);
    bus.req_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", bus.res_valid, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_fu_x1", bus.fu_x1, 32'h0);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("post_rst_results", 64'(seen), 64'd0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end
endmodule
